address_table_arbiter: RTL and testbench

Shares the single learn/lookup port pair of the switch MAC address table among NUM_PORTS ingress ports. Each ingress port posts one request per frame: learn its source MAC and resolve its destination MAC. A round-robin arbiter picks one request, drives the table for one cycle and captures the registered lookup result. It then returns a forward, flood or drop decision to the granted port. The block sits between the per-port ingress parsers and the address table.

---
 rtl/switch_pkg.sv | 15 +
 rtl/address_table_arbiter_if.sv | 42 ++++
 rtl/address_table_arbiter_rr_arbiter.sv | 29 ++
 rtl/address_table_arbiter.sv | 126 ++++++++++++
 tb/tb_address_table_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_pkg.sv
// Shared constants and types for the switch address-table front end.
package switch_pkg;

  localparam int MAC_W         = 48;
  localparam int MAC_GROUP_BIT = 40;
  localparam logic [MAC_W-1:0] BROADCAST_MAC = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESPOND
  } arb_state_t;

endpackage

// File: rtl/address_table_arbiter_if.sv
// Request/response and address-table signals shared by the ingress ports and the arbiter.
interface address_table_arbiter_if
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]       req_valid_i;
  logic [NUM_PORTS*MAC_W-1:0] req_src_mac_i;
  logic [NUM_PORTS*MAC_W-1:0] req_dst_mac_i;
  logic [NUM_PORTS-1:0]       req_ready_o;
  logic [NUM_PORTS-1:0]       resp_valid_o;
  logic [PW-1:0]              resp_port_o;
  logic                       resp_flood_o;
  logic                       resp_drop_o;
  logic                       tbl_learn_req_o;
  logic [MAC_W-1:0]           tbl_learn_address_o;
  logic [PW-1:0]              tbl_learn_port_o;
  logic                       tbl_read_req_o;
  logic [MAC_W-1:0]           tbl_read_address_o;
  logic [PW-1:0]              tbl_read_port_i;
  logic                       tbl_read_port_valid_i;
  logic                       busy_o;

  modport slave (
    input  req_valid_i, req_src_mac_i, req_dst_mac_i,
    input  tbl_read_port_i, tbl_read_port_valid_i,
    output req_ready_o, resp_valid_o, resp_port_o, resp_flood_o, resp_drop_o,
    output tbl_learn_req_o, tbl_learn_address_o, tbl_learn_port_o,
    output tbl_read_req_o, tbl_read_address_o, busy_o
  );

  modport master (
    output req_valid_i, req_src_mac_i, req_dst_mac_i,
    output tbl_read_port_i, tbl_read_port_valid_i,
    input  req_ready_o, resp_valid_o, resp_port_o, resp_flood_o, resp_drop_o,
    input  tbl_learn_req_o, tbl_learn_address_o, tbl_learn_port_o,
    input  tbl_read_req_o, tbl_read_address_o, busy_o
  );

endinterface

// File: rtl/address_table_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant_idx,
  output logic          any_req
);

  int unsigned idx;

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      // wrap at N, not 2^PW, so non-power-of-two port counts stay in range
      if (idx >= N) idx = idx - N;
      if (!any_req && req[idx[PW-1:0]]) begin
        any_req   = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/address_table_arbiter.sv
// Shares the MAC table learn/lookup ports among NUM_PORTS ingress parsers, one request per 4 cycles.
module address_table_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int LEARN_ENABLE = 1
) (
  input  logic clk,
  input  logic rst,
  address_table_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);

  arb_state_t state, state_nxt;

  logic [PW-1:0]        ptr, ptr_nxt, grant_q, grant_nxt, arb_idx;
  logic                 arb_any;
  logic [MAC_W-1:0]     src_q, src_nxt, dst_q, dst_nxt;
  logic [MAC_W-1:0]     src_arr [NUM_PORTS];
  logic [MAC_W-1:0]     dst_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] ready_q, ready_nxt, resp_valid_q, resp_valid_nxt;
  logic [PW-1:0]        resp_port_q, resp_port_nxt;
  logic                 flood_q, flood_nxt, drop_q, drop_nxt;
  logic                 learn_q, learn_nxt, read_q, read_nxt, busy_q, busy_nxt;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign src_arr[p] = bus.req_src_mac_i[p*MAC_W +: MAC_W];
    assign dst_arr[p] = bus.req_dst_mac_i[p*MAC_W +: MAC_W];
  end

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req       (bus.req_valid_i),
    .ptr       (ptr),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      grant_q      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      ready_q      <= '0;
      resp_valid_q <= '0;
      resp_port_q  <= '0;
      flood_q      <= 1'b0;
      drop_q       <= 1'b0;
      learn_q      <= 1'b0;
      read_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      grant_q      <= grant_nxt;
      src_q        <= src_nxt;
      dst_q        <= dst_nxt;
      ready_q      <= ready_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_port_q  <= resp_port_nxt;
      flood_q      <= flood_nxt;
      drop_q       <= drop_nxt;
      learn_q      <= learn_nxt;
      read_q       <= read_nxt;
      busy_q       <= busy_nxt;
    end
  end

  // Outputs are the registered image of the state being entered, so strobes and
  // responses appear exactly in ISSUE and RESPOND.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    grant_nxt      = grant_q;
    src_nxt        = src_q;
    dst_nxt        = dst_q;
    ready_nxt      = '0;
    resp_valid_nxt = '0;
    resp_port_nxt  = '0;
    flood_nxt      = 1'b0;
    drop_nxt       = 1'b0;
    learn_nxt      = 1'b0;
    read_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          grant_nxt          = arb_idx;
          src_nxt            = src_arr[arb_idx];
          dst_nxt            = dst_arr[arb_idx];
          ready_nxt[arb_idx] = 1'b1;
          learn_nxt          = (LEARN_ENABLE != 0) && !src_arr[arb_idx][MAC_GROUP_BIT];
          read_nxt           = !dst_arr[arb_idx][MAC_GROUP_BIT];
          state_nxt          = ISSUE;
        end
      end
      ISSUE: state_nxt = CAPTURE;
      CAPTURE: begin
        resp_valid_nxt[grant_q] = 1'b1;
        if (dst_q[MAC_GROUP_BIT] || !bus.tbl_read_port_valid_i) flood_nxt = 1'b1;
        else if (bus.tbl_read_port_i == grant_q)                drop_nxt  = 1'b1;
        else                                                    resp_port_nxt = bus.tbl_read_port_i;
        state_nxt = RESPOND;
      end
      RESPOND: begin
        ptr_nxt   = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.req_ready_o         = ready_q;
  assign bus.resp_valid_o        = resp_valid_q;
  assign bus.resp_port_o         = resp_port_q;
  assign bus.resp_flood_o        = flood_q;
  assign bus.resp_drop_o         = drop_q;
  assign bus.tbl_learn_req_o     = learn_q;
  assign bus.tbl_learn_address_o = src_q;
  assign bus.tbl_learn_port_o    = grant_q;
  assign bus.tbl_read_req_o      = read_q;
  assign bus.tbl_read_address_o  = dst_q;
  assign bus.busy_o              = busy_q;

endmodule

// File: tb/tb_address_table_arbiter.sv
// Randomized bench for address_table_arbiter: 4-port learning build plus 3-port lookup-only build.
module tb_address_table_arbiter;
  import switch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  address_table_arbiter_if #(.NUM_PORTS(4)) ia ();
  address_table_arbiter_if #(.NUM_PORTS(3)) ib ();

  address_table_arbiter #(.NUM_PORTS(4), .LEARN_ENABLE(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  address_table_arbiter #(.NUM_PORTS(3), .LEARN_ENABLE(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  logic [47:0] a_src [4];
  logic [47:0] a_dst [4];
  logic [47:0] b_src [3];
  logic [47:0] b_dst [3];
  int env_tbl [logic [47:0]];   // table contents as written by DUT strobes
  int ref_tbl [logic [47:0]];   // table contents predicted from the learning rules
  int exp_ptr_a = 0;
  int exp_ptr_b = 0;
  int learn_b_cnt = 0;

  // Behavioural MAC table for DUT A: registered lookup result, read-before-write.
  initial begin
    ia.tbl_read_port_i       = '0;
    ia.tbl_read_port_valid_i = 1'b0;
    forever begin
      @(posedge clk);
      if (ia.tbl_read_req_o) begin
        if (env_tbl.exists(ia.tbl_read_address_o)) begin
          ia.tbl_read_port_valid_i = 1'b1;
          ia.tbl_read_port_i       = 2'(env_tbl[ia.tbl_read_address_o]);
        end else begin
          ia.tbl_read_port_valid_i = 1'b0;
          ia.tbl_read_port_i       = '0;
        end
      end
      if (ia.tbl_learn_req_o) env_tbl[ia.tbl_learn_address_o] = int'(ia.tbl_learn_port_o);
    end
  end

  always @(negedge clk) if (ib.tbl_learn_req_o) learn_b_cnt++;

  function automatic logic [47:0] rand_mac();
    logic [47:0] pool [5];
    int k;
    pool[0] = 48'h001122334455;
    pool[1] = 48'h00DEADBEEF01;
    pool[2] = 48'h000A0B0C0D0E;
    pool[3] = 48'h020000000042;
    pool[4] = 48'h00AABBCCDDEE;
    k = $urandom_range(6, 0);
    if (k < 5) return pool[k];
    if (k == 5) return BROADCAST_MAC;
    return {24'h01005E, 24'($urandom)};
  endfunction

  task automatic set_a(input int p, input logic [47:0] s, input logic [47:0] d);
    a_src[2'(p)] = s;
    a_dst[2'(p)] = d;
    ia.req_src_mac_i = {a_src[3], a_src[2], a_src[1], a_src[0]};
    ia.req_dst_mac_i = {a_dst[3], a_dst[2], a_dst[1], a_dst[0]};
    ia.req_valid_i[2'(p)] = 1'b1;
  endtask

  // Serves one request on DUT A. Entered at the falling edge of an IDLE cycle.
  task automatic run_txn(output int og, output logic f, output logic dr, output logic [1:0] pt,
                         output logic lr, output logic rr);
    logic [47:0] s, d;
    logic        hit, ef, ed;
    logic [1:0]  ep;
    logic [3:0]  onehot;
    int g, tp;
    og = -1; f = 1'b0; dr = 1'b0; pt = '0; lr = 1'b0; rr = 1'b0;
    g = -1;
    for (int i = 0; i < 4; i++) begin
      automatic int p = (exp_ptr_a + i) % 4;
      if (g < 0 && ia.req_valid_i[2'(p)]) g = p;
    end
    if (g < 0) begin
      checks++; errors++;
      $display("FAIL run_txn: no request pending in bench");
      return;
    end
    s = a_src[2'(g)];
    d = a_dst[2'(g)];
    hit = !d[40] && ref_tbl.exists(d);
    tp  = hit ? ref_tbl[d] : 0;
    ef  = d[40] || !hit;
    ed  = hit && (tp == g);
    ep  = (ef || ed) ? 2'd0 : 2'(tp);
    onehot = 4'b0001 << g;

    @(negedge clk);  // ISSUE
    for (int i = 0; i < 4; i++) if (ia.req_ready_o[2'(i)]) og = i;
    checks++;
    if (ia.req_ready_o !== onehot) begin
      errors++; $display("FAIL grant: req_ready_o=%b expected %b", ia.req_ready_o, onehot);
    end
    checks++;
    if (ia.tbl_learn_req_o !== !s[40]) begin
      errors++; $display("FAIL learn_req: got %b expected %b", ia.tbl_learn_req_o, !s[40]);
    end
    if (!s[40]) begin
      checks++;
      if ({ia.tbl_learn_address_o, ia.tbl_learn_port_o} !== {s, 2'(g)}) begin
        errors++; $display("FAIL learn_data: got %h/%0d expected %h/%0d",
                           ia.tbl_learn_address_o, ia.tbl_learn_port_o, s, g);
      end
      ref_tbl[s] = g;
    end
    checks++;
    if (ia.tbl_read_req_o !== !d[40]) begin
      errors++; $display("FAIL read_req: got %b expected %b", ia.tbl_read_req_o, !d[40]);
    end
    if (!d[40]) begin
      checks++;
      if (ia.tbl_read_address_o !== d) begin
        errors++; $display("FAIL read_addr: got %h expected %h", ia.tbl_read_address_o, d);
      end
    end
    checks++;
    if (ia.busy_o !== 1'b1) begin
      errors++; $display("FAIL busy_issue: got %b expected 1", ia.busy_o);
    end
    lr = ia.tbl_learn_req_o;
    rr = ia.tbl_read_req_o;
    ia.req_valid_i[2'(g)] = 1'b0;

    @(negedge clk);  // CAPTURE
    checks++;
    if ({ia.req_ready_o, ia.resp_valid_o} !== 8'h00) begin
      errors++; $display("FAIL capture_quiet: ready=%b resp_valid=%b expected 0",
                         ia.req_ready_o, ia.resp_valid_o);
    end

    @(negedge clk);  // RESPOND
    checks++;
    if (ia.resp_valid_o !== onehot) begin
      errors++; $display("FAIL resp_valid: got %b expected %b", ia.resp_valid_o, onehot);
    end
    checks++;
    if ({ia.resp_flood_o, ia.resp_drop_o, ia.resp_port_o} !== {ef, ed, ep}) begin
      errors++; $display("FAIL decision: flood/drop/port=%b/%b/%0d expected %b/%b/%0d",
                         ia.resp_flood_o, ia.resp_drop_o, ia.resp_port_o, ef, ed, ep);
    end
    f = ia.resp_flood_o; dr = ia.resp_drop_o; pt = ia.resp_port_o;

    @(negedge clk);  // IDLE
    checks++;
    if ({ia.busy_o, ia.resp_valid_o} !== 5'b0) begin
      errors++; $display("FAIL idle: busy=%b resp_valid=%b expected 0", ia.busy_o, ia.resp_valid_o);
    end
    exp_ptr_a = (g + 1) % 4;
  endtask

  task automatic test_reset();
    logic [199:0] va, vb;
    va = {ia.req_ready_o, ia.resp_valid_o, ia.resp_port_o, ia.resp_flood_o, ia.resp_drop_o,
          ia.tbl_learn_req_o, ia.tbl_learn_address_o, ia.tbl_learn_port_o,
          ia.tbl_read_req_o, ia.tbl_read_address_o, ia.busy_o};
    vb = {ib.req_ready_o, ib.resp_valid_o, ib.resp_port_o, ib.resp_flood_o, ib.resp_drop_o,
          ib.tbl_learn_req_o, ib.tbl_learn_address_o, ib.tbl_learn_port_o,
          ib.tbl_read_req_o, ib.tbl_read_address_o, ib.busy_o};
    checks++;
    if (va !== '0) begin errors++; $display("FAIL reset_a: outputs %h expected 0", va); end
    checks++;
    if (vb !== '0) begin errors++; $display("FAIL reset_b: outputs %h expected 0", vb); end
  endtask

  task automatic test_learn_disable();
    int g;
    logic [2:0] onehot;
    for (int r = 0; r < 100; r++) begin
      for (int p = 0; p < 3; p++) begin
        b_src[2'(p)] = rand_mac();
        b_dst[2'(p)] = rand_mac();
      end
      ib.req_src_mac_i = {b_src[2], b_src[1], b_src[0]};
      ib.req_dst_mac_i = {b_dst[2], b_dst[1], b_dst[0]};
      ib.req_valid_i   = 3'b111;
      g = exp_ptr_b;
      onehot = 3'b001 << g;
      @(negedge clk);
      checks++;
      if (ib.req_ready_o !== onehot || ib.tbl_learn_req_o !== 1'b0) begin
        errors++; $display("FAIL b_issue: ready=%b learn=%b expected %b/0",
                           ib.req_ready_o, ib.tbl_learn_req_o, onehot);
      end
      checks++;
      if (ib.tbl_read_req_o !== !b_dst[2'(g)][40]) begin
        errors++; $display("FAIL b_read_req: got %b expected %b", ib.tbl_read_req_o, !b_dst[2'(g)][40]);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ib.resp_valid_o, ib.resp_flood_o, ib.resp_drop_o, ib.resp_port_o} !== {onehot, 1'b1, 1'b0, 2'd0}) begin
        errors++; $display("FAIL b_resp: valid=%b flood=%b drop=%b port=%0d expected %b/1/0/0",
                           ib.resp_valid_o, ib.resp_flood_o, ib.resp_drop_o, ib.resp_port_o, onehot);
      end
      @(negedge clk);
      exp_ptr_b = (g + 1) % 3;
    end
    ib.req_valid_i = '0;
    checks++;
    if (learn_b_cnt != 0) begin
      errors++; $display("FAIL b_no_learn: learn strobes=%0d expected 0", learn_b_cnt);
    end
  endtask

  task automatic test_single();
    int og; logic f, dr, lr, rr; logic [1:0] pt;
    set_a(1, 48'h001122334455, 48'h00DEADBEEF02);
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if ({og[1:0], lr, rr, f, dr} !== {2'd1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL single: grant=%0d learn=%b read=%b flood=%b drop=%b expected 1/1/1/1/0",
                         og, lr, rr, f, dr);
    end
  endtask

  task automatic test_forward_drop();
    int og; logic f, dr, lr, rr; logic [1:0] pt;
    set_a(2, 48'h00DEADBEEF01, BROADCAST_MAC);
    run_txn(og, f, dr, pt, lr, rr);
    set_a(1, 48'h001122334455, 48'h00DEADBEEF01);
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if ({f, dr, pt} !== {1'b0, 1'b0, 2'd2}) begin
      errors++; $display("FAIL forward: flood/drop/port=%b/%b/%0d expected 0/0/2", f, dr, pt);
    end
    set_a(1, 48'h00DEADBEEF01, BROADCAST_MAC);
    run_txn(og, f, dr, pt, lr, rr);
    set_a(1, 48'h001122334455, 48'h00DEADBEEF01);
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if ({f, dr, pt} !== {1'b0, 1'b1, 2'd0}) begin
      errors++; $display("FAIL drop: flood/drop/port=%b/%b/%0d expected 0/1/0", f, dr, pt);
    end
  endtask

  task automatic test_broadcast_multicast();
    int og; logic f, dr, lr, rr; logic [1:0] pt;
    set_a(0, 48'h000A0B0C0D0E, BROADCAST_MAC);
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if ({rr, lr, f} !== 3'b011) begin
      errors++; $display("FAIL broadcast: read=%b learn=%b flood=%b expected 0/1/1", rr, lr, f);
    end
    set_a(3, 48'h01005E000001, 48'h001122334455);
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if ({lr, rr, f, pt} !== {1'b0, 1'b1, 1'b0, 2'd1}) begin
      errors++; $display("FAIL mcast_src: learn=%b read=%b flood=%b port=%0d expected 0/1/0/1", lr, rr, f, pt);
    end
  endtask

  task automatic test_round_robin();
    int og, start; logic f, dr, lr, rr; logic [1:0] pt;
    for (int p = 0; p < 4; p++) set_a(p, rand_mac(), rand_mac());
    start = exp_ptr_a;
    for (int k = 0; k < 5; k++) begin
      run_txn(og, f, dr, pt, lr, rr);
      checks++;
      if (og != (start + k) % 4) begin
        errors++; $display("FAIL rr_order: step %0d grant=%0d expected %0d", k, og, (start + k) % 4);
      end
      if (og >= 0) set_a(og, rand_mac(), rand_mac());
    end
  endtask

  task automatic test_random();
    int og; logic f, dr, lr, rr; logic [1:0] pt;
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 4; p++)
        if (!ia.req_valid_i[2'(p)] && $urandom_range(1, 0) == 1) set_a(p, rand_mac(), rand_mac());
      if (ia.req_valid_i == '0) set_a($urandom_range(3, 0), rand_mac(), rand_mac());
      run_txn(og, f, dr, pt, lr, rr);
    end
    for (int r = 0; r < 4; r++)
      if (ia.req_valid_i != '0) run_txn(og, f, dr, pt, lr, rr);
  endtask

  task automatic test_reset_midflight();
    int og; logic f, dr, lr, rr; logic [1:0] pt;
    logic [199:0] va;
    set_a(2, 48'h020000000042, BROADCAST_MAC);
    run_txn(og, f, dr, pt, lr, rr);
    set_a(1, 48'h00AABBCCDDEE, 48'h000A0B0C0D0E);
    set_a(3, 48'h001122334455, 48'h00DEADBEEF01);
    @(negedge clk);  // ISSUE of port 3, pointer sits at 3
    checks++;
    if (ia.req_ready_o !== 4'b1000) begin
      errors++; $display("FAIL pre_reset_grant: ready=%b expected 1000", ia.req_ready_o);
    end
    ref_tbl[a_src[3]] = 3;
    @(posedge clk);  // now in CAPTURE
    #2 rst = 1'b1;
    #1;
    va = {ia.req_ready_o, ia.resp_valid_o, ia.resp_port_o, ia.resp_flood_o, ia.resp_drop_o,
          ia.tbl_learn_req_o, ia.tbl_learn_address_o, ia.tbl_learn_port_o,
          ia.tbl_read_req_o, ia.tbl_read_address_o, ia.busy_o};
    checks++;
    if (va !== '0) begin errors++; $display("FAIL midflight_reset: outputs %h expected 0", va); end
    @(negedge clk);
    @(negedge clk);  // cycle where the lost response would have appeared
    checks++;
    if ({ia.resp_valid_o, ia.busy_o} !== 5'b0) begin
      errors++; $display("FAIL lost_resp: resp_valid=%b busy=%b expected 0", ia.resp_valid_o, ia.busy_o);
    end
    rst = 1'b0;
    exp_ptr_a = 0;
    exp_ptr_b = 0;
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if (og != 1) begin errors++; $display("FAIL regrant_first: grant=%0d expected 1", og); end
    run_txn(og, f, dr, pt, lr, rr);
    checks++;
    if (og != 3) begin errors++; $display("FAIL regrant_held: grant=%0d expected 3", og); end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin a_src[p] = '0; a_dst[p] = '0; end
    for (int p = 0; p < 3; p++) begin b_src[p] = '0; b_dst[p] = '0; end
    ia.req_valid_i = '0; ia.req_src_mac_i = '0; ia.req_dst_mac_i = '0;
    ib.req_valid_i = '0; ib.req_src_mac_i = '0; ib.req_dst_mac_i = '0;
    ib.tbl_read_port_i = '0; ib.tbl_read_port_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_learn_disable();
    test_single();
    test_forward_drop();
    test_broadcast_multicast();
    test_round_robin();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
